// File: rtl/usb_desc_pkg.sv
// usb_desc_pkg: descriptor constants, fetch FSM states and error codes
package usb_desc_pkg;
  localparam logic [7:0] DT_DEVICE = 8'h01;
  localparam logic [7:0] DT_CONFIG = 8'h02;
  localparam logic [7:0] DT_INTERFACE = 8'h04;
  localparam logic [7:0] DT_ENDPOINT = 8'h05;
  localparam logic [15:0] DEV_DESC_LEN = 16'd18;
  localparam logic [15:0] CFG_HDR_LEN = 16'd9;
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_XFER = 2'd2;
  localparam logic [1:0] ERR_BAD_LEN = 2'd3;
  typedef enum logic [3:0] {
    S_IDLE, S_REQ_DEV, S_RX_DEV, S_REQ_CFGH, S_RX_CFGH, S_REQ_CFG, S_RX_CFG,
    S_WAIT_PSR, S_RESTART, S_DONE, S_FAIL
  } state_e;
endpackage

// File: rtl/desc_fetch_timer.sv
// desc_fetch_timer: reloadable idle down-counter; expired once CYCLES cycles pass without load
module desc_fetch_timer #(
  parameter int CYCLES = 60000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic expired
);
  localparam int W = $clog2(CYCLES + 1);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else if (load) cnt_q <= W'(CYCLES);
    else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  assign expired = cnt_q == '0;
endmodule

// File: rtl/usb_desc_fetch_ctrl.sv
// usb_desc_fetch_ctrl: fetches device/config descriptors and streams them to the parser.
// Optional stat_bytes/stat_retries counters when DESC_FETCH_STATS_EN is defined.
module usb_desc_fetch_ctrl
  import usb_desc_pkg::*;
#(
  parameter int MAX_CFG_LEN    = 512,
  parameter int TIMEOUT_CYCLES = 60000,
  parameter int MAX_RETRIES    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [15:0] total_len,
  output logic        ctl_req_valid,
  input  logic        ctl_req_ready,
  output logic [7:0]  ctl_req_desc_type,
  output logic [15:0] ctl_req_length,
  input  logic [7:0]  ctl_rx_data,
  input  logic        ctl_rx_valid,
  output logic        ctl_rx_ready,
  input  logic        ctl_xfer_done,
  input  logic        ctl_xfer_err,
  output logic        psr_enable,
  output logic [7:0]  psr_data,
  output logic        psr_valid,
  input  logic        psr_ready,
  input  logic        psr_done,
  input  logic        psr_found,
  output logic        ep_found
`ifdef DESC_FETCH_STATS_EN
  ,
  output logic [15:0] stat_bytes,
  output logic [7:0]  stat_retries
`endif
);
  localparam int RW = $clog2(MAX_RETRIES + 2);
  localparam logic [15:0] CAP = 16'(MAX_CFG_LEN);
  state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d, len_q, len_d, tot_q, tot_d;
  logic [RW-1:0] retry_q, retry_d;
  logic done_q, done_d, error_q, error_d, ep_q, ep_d;
  logic [1:0] err_q, err_d;
  logic rx, fwd, in_range, rx_acc, req_hs, expired, stall, xerr, load;
  assign rx = state_q inside {S_RX_DEV, S_RX_CFGH, S_RX_CFG};
  assign fwd = state_q == S_RX_DEV || state_q == S_RX_CFG;
  assign in_range = fwd && cnt_q < (state_q == S_RX_DEV ? DEV_DESC_LEN : tot_q);
  // bytes past the requested length are drained without reaching the parser
  assign psr_data = ctl_rx_data;
  assign psr_valid = in_range && ctl_rx_valid;
  assign ctl_rx_ready = rx && (!in_range || psr_ready);
  assign rx_acc = ctl_rx_valid && ctl_rx_ready;
  assign ctl_req_valid = state_q inside {S_REQ_DEV, S_REQ_CFGH, S_REQ_CFG};
  assign ctl_req_desc_type = state_q == S_REQ_DEV ? DT_DEVICE : ctl_req_valid ? DT_CONFIG : 8'h00;
  assign ctl_req_length = state_q == S_REQ_DEV ? DEV_DESC_LEN :
                          state_q == S_REQ_CFGH ? CFG_HDR_LEN :
                          state_q == S_REQ_CFG ? tot_q : 16'd0;
  assign req_hs = ctl_req_valid && ctl_req_ready;
  assign stall = (ctl_req_valid || rx) && expired && !req_hs && !rx_acc;
  assign xerr = rx && ctl_xfer_err;
  assign load = state_d != state_q || req_hs || rx_acc;
  assign busy = !(state_q inside {S_IDLE, S_DONE, S_FAIL});
  assign psr_enable = ctl_req_valid || rx || state_q == S_WAIT_PSR;
  assign done = done_q;
  assign error = error_q;
  assign err_code = err_q;
  assign total_len = tot_q;
  assign ep_found = ep_q;
  desc_fetch_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(clk), .rst_n(rst_n), .load(load), .expired(expired)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = req_hs ? 16'd0 : (rx_acc && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    len_d = req_hs ? 16'd0 : len_q;
    if (state_q == S_RX_CFGH && rx_acc && cnt_q == 16'd2) len_d[7:0] = ctl_rx_data;
    if (state_q == S_RX_CFGH && rx_acc && cnt_q == 16'd3) len_d[15:8] = ctl_rx_data;
    tot_d = tot_q;
    retry_d = retry_q;
    done_d = done_q;
    error_d = error_q;
    err_d = err_q;
    ep_d = ep_q || psr_found;
    if (stall || xerr) begin
      retry_d = retry_q + 1'b1;
      state_d = int'(retry_d) <= MAX_RETRIES ? S_RESTART : S_FAIL;
      error_d = int'(retry_d) > MAX_RETRIES;
      err_d = int'(retry_d) > MAX_RETRIES ? (xerr ? ERR_XFER : ERR_TIMEOUT) : ERR_NONE;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          state_d = S_REQ_DEV;
          tot_d = '0;
          retry_d = '0;
          done_d = 1'b0;
          error_d = 1'b0;
          err_d = ERR_NONE;
          ep_d = 1'b0;
        end
        S_REQ_DEV: if (req_hs) state_d = S_RX_DEV;
        S_RX_DEV: if (ctl_xfer_done) state_d = S_REQ_CFGH;
        S_REQ_CFGH: if (req_hs) state_d = S_RX_CFGH;
        S_RX_CFGH: if (ctl_xfer_done) begin
          state_d = len_d < CFG_HDR_LEN ? S_FAIL : S_REQ_CFG;
          error_d = len_d < CFG_HDR_LEN;
          err_d = len_d < CFG_HDR_LEN ? ERR_BAD_LEN : ERR_NONE;
          tot_d = len_d < CFG_HDR_LEN ? tot_q : len_d > CAP ? CAP : len_d;
        end
        S_REQ_CFG: if (req_hs) state_d = S_RX_CFG;
        S_RX_CFG: if (ctl_xfer_done) state_d = S_WAIT_PSR;
        S_WAIT_PSR: if (psr_done || expired) begin
          state_d = S_DONE;
          done_d = 1'b1;
        end
        S_RESTART: state_d = S_REQ_DEV;
        S_DONE, S_FAIL: if (start) begin
          state_d = S_IDLE;
          done_d = 1'b0;
          error_d = 1'b0;
          err_d = ERR_NONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      len_q <= '0;
      tot_q <= '0;
      retry_q <= '0;
      done_q <= 1'b0;
      error_q <= 1'b0;
      err_q <= ERR_NONE;
      ep_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      tot_q <= tot_d;
      retry_q <= retry_d;
      done_q <= done_d;
      error_q <= error_d;
      err_q <= err_d;
      ep_q <= ep_d;
    end
`ifdef DESC_FETCH_STATS_EN
  logic [15:0] stat_bytes_q;
  logic [7:0] stat_retries_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stat_bytes_q <= '0;
      stat_retries_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      stat_bytes_q <= '0;
      stat_retries_q <= '0;
    end else begin
      if (psr_valid && psr_ready && stat_bytes_q != 16'hFFFF) stat_bytes_q <= stat_bytes_q + 16'd1;
      if ((stall || xerr) && stat_retries_q != 8'hFF) stat_retries_q <= stat_retries_q + 8'd1;
    end
  assign stat_bytes = stat_bytes_q;
  assign stat_retries = stat_retries_q;
`endif
endmodule

// File: tb/tb_usb_desc_fetch_ctrl.sv
// tb_usb_desc_fetch_ctrl: randomized engine/parser stimulus checked against a byte-stream model
module tb_usb_desc_fetch_ctrl;
  localparam int TO = 300;
  typedef logic [7:0] bq_t[$];
  logic clk, rst_n, start, busy, done, error, ctl_req_valid, ctl_req_ready, ctl_rx_valid, ctl_rx_ready;
  logic ctl_xfer_done, ctl_xfer_err, psr_enable, psr_valid, psr_ready, psr_done, psr_found, ep_found;
  logic [1:0] err_code;
  logic [15:0] total_len, ctl_req_length;
  logic [7:0] ctl_req_desc_type, ctl_rx_data, psr_data;
`ifdef DESC_FETCH_STATS_EN
  logic [15:0] stat_bytes;
  logic [7:0] stat_retries;
`endif
  int n_cmp = 0, n_fail = 0, psr_mode = 0;
  bq_t req_log, psr_log;
  usb_desc_fetch_ctrl #(.MAX_CFG_LEN(512), .TIMEOUT_CYCLES(TO), .MAX_RETRIES(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .error(error),
    .err_code(err_code), .total_len(total_len), .ctl_req_valid(ctl_req_valid),
    .ctl_req_ready(ctl_req_ready), .ctl_req_desc_type(ctl_req_desc_type),
    .ctl_req_length(ctl_req_length), .ctl_rx_data(ctl_rx_data), .ctl_rx_valid(ctl_rx_valid),
    .ctl_rx_ready(ctl_rx_ready), .ctl_xfer_done(ctl_xfer_done), .ctl_xfer_err(ctl_xfer_err),
    .psr_enable(psr_enable), .psr_data(psr_data), .psr_valid(psr_valid), .psr_ready(psr_ready),
    .psr_done(psr_done), .psr_found(psr_found), .ep_found(ep_found)
`ifdef DESC_FETCH_STATS_EN
    , .stat_bytes(stat_bytes), .stat_retries(stat_retries)
`endif
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial begin
    psr_ready = 1;
    forever begin
      @(negedge clk);
      psr_ready = psr_mode == 0 ? 1'b1 : psr_mode == 1 ? ~psr_ready : 1'($urandom_range(0, 1));
    end
  end
  // log every request handshake and every byte the parser accepts
  initial forever begin
    @(negedge clk);
    #2;
    if (ctl_req_valid && ctl_req_ready) begin
      req_log.push_back(ctl_req_desc_type);
      req_log.push_back(ctl_req_length[15:8]);
      req_log.push_back(ctl_req_length[7:0]);
    end
    if (psr_valid && psr_ready) psr_log.push_back(psr_data);
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  function automatic bit same(bq_t a, bq_t b);
    if (a.size() != b.size()) return 0;
    foreach (a[i]) if (a[i] !== b[i]) return 0;
    return 1;
  endfunction
  // boot-keyboard check: endpoint IN interrupt inside an interface of class 03/01/01
  function automatic bit kbd_ep(bq_t q);
    bit in_kbd = 0;
    int i = 0;
    while (i + 1 < q.size()) begin
      int l = int'(q[i]);
      if (l < 2) break;
      if (q[i+1] == 8'h04 && i + 7 < q.size()) in_kbd = q[i+5] == 8'h03 && q[i+6] == 8'h01 && q[i+7] == 8'h01;
      if (q[i+1] == 8'h05 && i + 3 < q.size() && in_kbd && q[i+2][7] && q[i+3][1:0] == 2'b11) return 1;
      i += l;
    end
    return 0;
  endfunction
  function automatic bq_t exp_stream(bq_t dev, bq_t cfg, int tot);
    bq_t r;
    for (int i = 0; i < dev.size() && i < 18; i++) r.push_back(dev[i]);
    for (int i = 0; i < cfg.size() && i < tot; i++) r.push_back(cfg[i]);
    return r;
  endfunction
  function automatic bq_t exp_reqs(int tot);
    bq_t r = '{8'h01, 8'h00, 8'd18, 8'h02, 8'h00, 8'd9, 8'h02};
    r.push_back(8'(tot >> 8));
    r.push_back(8'(tot));
    return r;
  endfunction
  function automatic int cap(int w);
    return w > 512 ? 512 : w;
  endfunction
  function automatic bq_t rand_cfg(int n, int wtot);
    bq_t r;
    for (int i = 0; i < n; i++) r.push_back(8'($urandom));
    r[0] = 8'h09;
    r[1] = 8'h02;
    r[2] = 8'(wtot);
    r[3] = 8'(wtot >> 8);
    return r;
  endfunction
  task automatic do_req(input string nm);
    int t = 0;
    while (!ctl_req_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!ctl_req_valid) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: ctl_req_valid never rose within 50 cycles", nm);
      return;
    end
    repeat ($urandom_range(0, 3)) @(negedge clk);
    ctl_req_ready = 1;
    @(negedge clk);
    ctl_req_ready = 0;
  endtask
  task automatic send_bytes(input bq_t d, input bit merge, input bit err, input bit chk);
    for (int i = 0; i < d.size(); i++) begin
      int t = 0;
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      ctl_rx_valid = 1;
      ctl_rx_data = d[i];
      #1;
      while (!ctl_rx_ready && t < 100) begin
        if (chk && psr_valid) begin
          n_cmp++;
          if (ctl_rx_ready !== psr_ready) begin
            n_fail++;
            $display("FAIL rx_ready_mirror: ctl_rx_ready=%b psr_ready=%b", ctl_rx_ready, psr_ready);
          end
        end
        @(negedge clk);
        #1;
        t++;
      end
      if (chk && psr_valid) begin
        n_cmp++;
        if (ctl_rx_ready !== psr_ready) begin
          n_fail++;
          $display("FAIL rx_ready_mirror: ctl_rx_ready=%b psr_ready=%b", ctl_rx_ready, psr_ready);
        end
      end
      if (!ctl_rx_ready) begin
        n_cmp++;
        n_fail++;
        $display("FAIL rx_accept: byte %0d not accepted within 100 cycles", i);
      end
      if (merge && i == d.size() - 1) begin
        ctl_xfer_done = 1;
        ctl_xfer_err = err;
      end
      @(negedge clk);
      ctl_rx_valid = 0;
    end
    if (!merge || d.size() == 0) begin
      ctl_xfer_done = 1;
      ctl_xfer_err = err;
      @(negedge clk);
    end
    ctl_xfer_done = 0;
    ctl_xfer_err = 0;
  endtask
  task automatic wait_end(input string nm);
    int t = 0;
    while (!(done || error) && t < TO + 50) begin
      @(negedge clk);
      t++;
    end
    if (!(done || error)) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: neither done nor error within %0d cycles", nm, TO + 50);
    end
  endtask
  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic fetch(input bq_t dev, input bq_t cfg, input bit give_done, input bit chk);
    do_req("req_dev");
    send_bytes(dev, $urandom_range(0, 1), 0, chk);
    do_req("req_cfgh");
    send_bytes(cfg[0:8], $urandom_range(0, 1), 0, 0);
    do_req("req_cfg");
    send_bytes(cfg, $urandom_range(0, 1), 0, chk);
    if (kbd_ep(cfg)) begin
      psr_found = 1;
      @(negedge clk);
      psr_found = 0;
    end
    if (give_done) begin
      repeat (3) @(negedge clk);
      psr_done = 1;
      @(negedge clk);
      psr_done = 0;
    end
    wait_end("fetch_end");
  endtask
  task automatic go_idle();
    if (done || error) begin
      pulse_start();
      n_cmp++;
      if ({busy, done, error, err_code} !== 5'b0) begin
        n_fail++;
        $display("FAIL leave_end: busy/done/error/err_code=%b required 0", {busy, done, error, err_code});
      end
    end
    req_log.delete();
    psr_log.delete();
  endtask
  task automatic check_result(input string nm, input bit exp_done, input logic [1:0] exp_err,
                              input int exp_tot, input bit exp_ep, input bq_t er, input bq_t eb);
    n_cmp++;
    if (done !== exp_done || error !== !exp_done || err_code !== exp_err || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_status: done=%b error=%b err_code=%0d busy=%b required done=%b err_code=%0d",
               nm, done, error, err_code, busy, exp_done, exp_err);
    end
    n_cmp++;
    if (total_len !== 16'(exp_tot)) begin
      n_fail++;
      $display("FAIL %s_total_len: got %0d required %0d", nm, total_len, exp_tot);
    end
    n_cmp++;
    if (ep_found !== exp_ep) begin
      n_fail++;
      $display("FAIL %s_ep_found: got %b required %b", nm, ep_found, exp_ep);
    end
    n_cmp++;
    if (!same(req_log, er)) begin
      n_fail++;
      $display("FAIL %s_requests: got %0d request bytes required %0d", nm, req_log.size(), er.size());
    end
    n_cmp++;
    if (!same(psr_log, eb)) begin
      n_fail++;
      $display("FAIL %s_stream: got %0d parser bytes required %0d", nm, psr_log.size(), eb.size());
    end
  endtask
  task automatic test_reset();
    rst_n = 0;
    {start, ctl_req_ready, ctl_rx_valid, ctl_xfer_done, ctl_xfer_err, psr_done, psr_found} = '0;
    ctl_rx_data = 0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, error, err_code, total_len, ctl_req_valid, ctl_req_desc_type, ctl_req_length,
         ctl_rx_ready, psr_enable, psr_valid, ep_found} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: some output nonzero, busy=%b req_valid=%b psr_enable=%b total_len=%0d",
               busy, ctl_req_valid, psr_enable, total_len);
    end
    rst_n = 1;
    @(negedge clk);
  endtask
  task automatic test_keyboard();
    bq_t dev = '{8'h12, 8'h01, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h40, 8'h6D, 8'h04, 8'h1C, 8'hC3,
                 8'h00, 8'h01, 8'h01, 8'h02, 8'h00, 8'h01};
    bq_t cfg = '{8'h09, 8'h02, 8'h22, 8'h00, 8'h01, 8'h01, 8'h00, 8'hA0, 8'h32,
                 8'h09, 8'h04, 8'h00, 8'h00, 8'h01, 8'h03, 8'h01, 8'h01, 8'h00,
                 8'h09, 8'h21, 8'h11, 8'h01, 8'h00, 8'h01, 8'h22, 8'h3F, 8'h00,
                 8'h07, 8'h05, 8'h81, 8'h03, 8'h08, 8'h00, 8'h0A};
    go_idle();
    psr_mode = 0;
    start = 1;
    #1;
    n_cmp++;
    if (ctl_req_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_latency_early: req_valid=%b busy=%b required 0 before the edge", ctl_req_valid, busy);
    end
    @(negedge clk);
    start = 0;
    n_cmp++;
    if (ctl_req_valid !== 1'b1 || busy !== 1'b1 || psr_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL start_latency: req_valid=%b busy=%b psr_enable=%b required 1", ctl_req_valid, busy, psr_enable);
    end
    fetch(dev, cfg, 1, 1);
    check_result("keyboard", 1, 2'd0, 34, kbd_ep(cfg), exp_reqs(34), exp_stream(dev, cfg, 34));
    n_cmp++;
    if (psr_log.size() != 52 || ep_found !== 1'b1) begin
      n_fail++;
      $display("FAIL keyboard_count: got %0d bytes ep_found=%b required 52 and 1", psr_log.size(), ep_found);
    end
  endtask
  task automatic test_toggle();
    bq_t dev, cfg;
    go_idle();
    psr_mode = 1;
    for (int i = 0; i < 20; i++) dev.push_back(8'($urandom));
    cfg = rand_cfg(45, 40);
    pulse_start();
    fetch(dev, cfg, 0, 1);
    check_result("toggle", 1, 2'd0, 40, kbd_ep(cfg), exp_reqs(40), exp_stream(dev, cfg, 40));
  endtask
  task automatic test_bad_len();
    bq_t dev, hdr = '{8'h09, 8'h02, 8'h05, 8'h00};
    bq_t er = '{8'h01, 8'h00, 8'd18, 8'h02, 8'h00, 8'd9};
    go_idle();
    psr_mode = 2;
    for (int i = 0; i < 18; i++) dev.push_back(8'($urandom));
    pulse_start();
    do_req("bad_len_req_dev");
    send_bytes(dev, 0, 0, 0);
    do_req("bad_len_req_cfgh");
    send_bytes(hdr, 1, 0, 0);
    repeat (20) @(negedge clk);
    check_result("bad_len", 0, 2'd3, 0, 0, er, exp_stream(dev, hdr, 0));
  endtask
  task automatic test_cap();
    bq_t dev, cfg;
    go_idle();
    psr_mode = 2;
    for (int i = 0; i < 18; i++) dev.push_back(8'($urandom));
    cfg = rand_cfg(60, 1000);
    pulse_start();
    fetch(dev, cfg, 1, 0);
    check_result("cap", 1, 2'd0, cap(1000), kbd_ep(cfg), exp_reqs(cap(1000)), exp_stream(dev, cfg, cap(1000)));
  endtask
  task automatic test_xfer_err();
    bq_t dev, cfg, part, eb, er;
    go_idle();
    psr_mode = 2;
    for (int i = 0; i < 18; i++) dev.push_back(8'($urandom));
    cfg = rand_cfg(34, 34);
    part = cfg[0:9];
    pulse_start();
    do_req("xerr_req_dev");
    send_bytes(dev, 0, 0, 0);
    do_req("xerr_req_cfgh");
    send_bytes(cfg[0:8], 0, 0, 0);
    do_req("xerr_req_cfg");
    send_bytes(part, 1, 1, 0);
    fetch(dev, cfg, 1, 0);
    eb = exp_stream(dev, part, 34);
    foreach (dev[i]) if (i < 18) eb.push_back(dev[i]);
    foreach (cfg[i]) eb.push_back(cfg[i]);
    er = exp_reqs(34);
    foreach (er[i]) if (i < 9) er.push_back(er[i]);
    check_result("xfer_err", 1, 2'd0, 34, kbd_ep(cfg), er, eb);
`ifdef DESC_FETCH_STATS_EN
    n_cmp++;
    if (stat_retries !== 8'd1 || stat_bytes !== 16'(eb.size())) begin
      n_fail++;
      $display("FAIL xfer_err_stats: retries=%0d bytes=%0d required 1 and %0d", stat_retries, stat_bytes, eb.size());
    end
`endif
  endtask
  task automatic test_timeout();
    int cyc = 0, att = 0, drops = 0;
    logic pv = 0, pe1 = 0, pe2 = 0;
    go_idle();
    pulse_start();
    while (!error && cyc < 4 * TO + 200) begin
      if (ctl_req_valid && !pv) att++;
      pv = ctl_req_valid;
      if (pe2 && !pe1 && psr_enable) drops++;
      pe2 = pe1;
      pe1 = psr_enable;
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (att != 4 || drops != 3) begin
      n_fail++;
      $display("FAIL timeout_attempts: attempts=%0d enable_drops=%0d required 4 and 3", att, drops);
    end
    n_cmp++;
    if (error !== 1'b1 || err_code !== 2'd1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_status: error=%b err_code=%0d done=%b required 1/1/0", error, err_code, done);
    end
    n_cmp++;
    if (cyc < 4 * TO || cyc > 4 * TO + 40) begin
      n_fail++;
      $display("FAIL timeout_duration: %0d cycles required %0d..%0d", cyc, 4 * TO, 4 * TO + 40);
    end
  endtask
  task automatic test_async_reset();
    int seen = 0;
    go_idle();
    pulse_start();
    do_req("arst_req_dev");
    ctl_rx_valid = 1;
    ctl_rx_data = 8'h12;
    n_cmp++;
    if (psr_enable !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_pre: psr_enable=%b busy=%b required 1", psr_enable, busy);
    end
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if ({busy, psr_enable, ctl_rx_ready, psr_valid, ctl_req_valid} !== 5'b0) begin
      n_fail++;
      $display("FAIL arst_immediate: busy/enable/rx_ready/psr_valid/req_valid=%b required 0",
               {busy, psr_enable, ctl_rx_ready, psr_valid, ctl_req_valid});
    end
    ctl_rx_valid = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (30) begin
      @(negedge clk);
      if (ctl_req_valid || busy) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL arst_no_reissue: request/busy seen in %0d cycles required 0", seen);
    end
  endtask
  initial begin
    test_reset();
    test_keyboard();
    test_toggle();
    test_bad_len();
    test_cap();
    test_xfer_err();
    test_timeout();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
